// File: rtl/wb8_rr_arbiter_pkg.sv
// wb8_pkg: shared types and constants for the wb8 round-robin arbiter.
//   state_t          arbiter FSM state (idle / transaction in flight)
//   WB8_DATA_W       Wishbone data width (8)
//   WB8_DEF_ADDR_W   default slave address width
//   WB8_MAX_MASTERS  largest supported requester count
//   idx_w()          width of an index into n items (at least 1 bit)
package wb8_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   localparam int WB8_DATA_W      = 8;
   localparam int WB8_DEF_ADDR_W  = 4;
   localparam int WB8_MAX_MASTERS = 4;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/wb8_rr_arbiter_if.sv
// wb8_rr_arbiter_if: bundle of all master-side and slave-side bus signals
// around the arbiter. Signal prefixes give direction as seen by the arbiter.
//   I_m_stb/we/adr/dat  per-master request, addresses and data packed
//                       master i at [i*ADDR_W +: ADDR_W] / [i*8 +: 8]
//   O_m_ack/err         per-master completion, one-hot or zero
//   O_m_dat             read data broadcast to all masters
//   O_s_stb/we/adr/dat  request forwarded to the single slave
//   I_s_ack/dat         slave response
//   O_grant             registered one-hot grant
// Modports: slave = arbiter side, master = environment (masters + slave) side.
interface wb8_rr_arbiter_if
   import wb8_pkg::*;
#(
   parameter int NUM_MASTERS = 2,
   parameter int ADDR_W      = WB8_DEF_ADDR_W
);
   logic [NUM_MASTERS-1:0]            I_m_stb;
   logic [NUM_MASTERS-1:0]            I_m_we;
   logic [NUM_MASTERS*ADDR_W-1:0]     I_m_adr;
   logic [NUM_MASTERS*WB8_DATA_W-1:0] I_m_dat;
   logic [NUM_MASTERS-1:0]            O_m_ack;
   logic [NUM_MASTERS-1:0]            O_m_err;
   logic [WB8_DATA_W-1:0]             O_m_dat;
   logic                              O_s_stb;
   logic                              O_s_we;
   logic [ADDR_W-1:0]                 O_s_adr;
   logic [WB8_DATA_W-1:0]             O_s_dat;
   logic                              I_s_ack;
   logic [WB8_DATA_W-1:0]             I_s_dat;
   logic [NUM_MASTERS-1:0]            O_grant;

   modport slave (
      input  I_m_stb, I_m_we, I_m_adr, I_m_dat, I_s_ack, I_s_dat,
      output O_m_ack, O_m_err, O_m_dat, O_s_stb, O_s_we, O_s_adr, O_s_dat, O_grant
   );

   modport master (
      output I_m_stb, I_m_we, I_m_adr, I_m_dat, I_s_ack, I_s_dat,
      input  O_m_ack, O_m_err, O_m_dat, O_s_stb, O_s_we, O_s_adr, O_s_dat, O_grant
   );
endinterface

// File: rtl/wb8_rr_arbiter_pick.sv
// wb8_rr_pick: combinational round-robin picker.
//   req    pending requests, one bit per master
//   last   index of the master served most recently
//   gnt    one-hot winner: first requester found scanning last+1 upward, wrapping
//   valid  at least one request pending
// The last-served master is scanned at the end, so it only wins again when
// nobody else is waiting.
module wb8_rr_pick
   import wb8_pkg::*;
#(
   parameter  int NUM_MASTERS = 2,
   localparam int LAST_W      = idx_w(NUM_MASTERS)
) (
   input  logic [NUM_MASTERS-1:0] req,
   input  logic [LAST_W-1:0]      last,
   output logic [NUM_MASTERS-1:0] gnt,
   output logic                   valid
);

   always_comb begin
      gnt   = '0;
      valid = 1'b0;
      for (int k = 1; k <= NUM_MASTERS; k++) begin
         if (!valid && req[(int'(last) + k) % NUM_MASTERS]) begin
            gnt[(int'(last) + k) % NUM_MASTERS] = 1'b1;
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb8_rr_arbiter.sv
// wb8_rr_arbiter: round-robin arbiter sharing one 8-bit Wishbone slave among
// NUM_MASTERS (2..4) masters, one transaction in flight at a time.
//   I_wb_clk  clock, all logic on posedge
//   I_reset   asynchronous active-high reset
//   bus       wb8_rr_arbiter_if.slave: master requests/responses, slave side, grant
// Flow: IDLE picks a requester and registers its one-hot grant; BUSY forwards
// the granted master's request to the slave combinationally and ends on slave
// ack, master abort (stb dropped) or, optionally, timeout. Every transaction
// passes through IDLE, so the slave strobe always drops between transactions.
// Optional feature: define WB8_ARB_TIMEOUT_EN to terminate a BUSY transaction
// with O_m_err after TIMEOUT_CYCLES cycles without ack. Without it O_m_err is
// tied low and BUSY lasts until ack or abort.
module wb8_rr_arbiter
   import wb8_pkg::*;
#(
   parameter int NUM_MASTERS    = 2,
   parameter int ADDR_W         = WB8_DEF_ADDR_W,
   parameter int TIMEOUT_CYCLES = 16
) (
   input logic                I_wb_clk,
   input logic                I_reset,
   wb8_rr_arbiter_if.slave    bus
);

   localparam int LAST_W = idx_w(NUM_MASTERS);

   state_t                   state, state_nxt;
   logic [NUM_MASTERS-1:0]   grant, grant_nxt;
   logic [LAST_W-1:0]        last, last_nxt;
   logic [LAST_W-1:0]        gidx;
   logic [NUM_MASTERS-1:0]   pick_gnt;
   logic                     pick_vld;
   logic                     busy;
   logic                     g_stb;
   logic                     ack_hit;
   logic                     abort_hit;
   logic                     to_hit;
   logic                     done;

   wb8_rr_pick #(.NUM_MASTERS(NUM_MASTERS)) u_pick (
      .req   (bus.I_m_stb),
      .last  (last),
      .gnt   (pick_gnt),
      .valid (pick_vld)
   );

   // Binary index of the registered one-hot grant.
   always_comb begin
      gidx = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (grant[i]) gidx = LAST_W'(i);
      end
   end

   assign busy      = (state == ST_BUSY);
   assign g_stb     = |(bus.I_m_stb & grant);
   assign ack_hit   = busy & bus.I_s_ack;
   // Ack takes priority over a simultaneous strobe drop.
   assign abort_hit = busy & ~g_stb & ~bus.I_s_ack;
   assign done      = ack_hit | abort_hit | to_hit;

`ifdef WB8_ARB_TIMEOUT_EN
   localparam int CNT_W = idx_w(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] cnt, cnt_nxt;

   // cnt equals the number of BUSY cycles already completed, so it reads 0 on
   // the first BUSY cycle and TIMEOUT_CYCLES-1 on the last one allowed.
   // Ack and abort both take priority over expiry.
   assign to_hit  = busy & g_stb & ~bus.I_s_ack & (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign cnt_nxt = (busy && !done) ? cnt + CNT_W'(1) : '0;

   always_ff @(posedge I_wb_clk or posedge I_reset) begin
      if (I_reset) cnt <= '0;
      else         cnt <= cnt_nxt;
   end

   assign bus.O_m_err = to_hit ? grant : '0;
`else
   assign to_hit      = 1'b0;
   assign bus.O_m_err = '0;
`endif

   always_ff @(posedge I_wb_clk or posedge I_reset) begin
      if (I_reset) begin
         state <= ST_IDLE;
         grant <= '0;
         last  <= LAST_W'(NUM_MASTERS - 1);
      end else begin
         state <= state_nxt;
         grant <= grant_nxt;
         last  <= last_nxt;
      end
   end

   // Next state plus the slave and return muxes. All outputs are gated by
   // BUSY, so reset (which forces IDLE) silences them immediately.
   always_comb begin
      state_nxt   = state;
      grant_nxt   = grant;
      last_nxt    = last;
      bus.O_s_stb = 1'b0;
      bus.O_s_we  = 1'b0;
      bus.O_s_adr = '0;
      bus.O_s_dat = '0;
      bus.O_m_dat = '0;
      bus.O_m_ack = '0;

      case (state)
         ST_IDLE: begin
            if (pick_vld) begin
               grant_nxt = pick_gnt;
               state_nxt = ST_BUSY;
            end
         end
         ST_BUSY: begin
            bus.O_s_stb = g_stb;
            bus.O_s_we  = |(bus.I_m_we & grant);
            bus.O_s_adr = bus.I_m_adr[int'(gidx)*ADDR_W +: ADDR_W];
            bus.O_s_dat = bus.I_m_dat[int'(gidx)*WB8_DATA_W +: WB8_DATA_W];
            bus.O_m_dat = bus.I_s_dat;
            if (ack_hit) bus.O_m_ack = grant;
            if (done) begin
               grant_nxt = '0;
               last_nxt  = gidx;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign bus.O_grant = grant;

endmodule

// File: tb/tb_wb8_rr_arbiter.sv
// Testbench for wb8_rr_arbiter: directed scenarios then randomized traffic,
// all outputs compared every cycle against a transaction-level model
// (current owner, last served, BUSY cycle count).
module tb_wb8_rr_arbiter;

   localparam int N  = 2;
   localparam int AW = 4;
   localparam int TO = 16;
`ifdef WB8_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   wb8_rr_arbiter_if #(.NUM_MASTERS(N), .ADDR_W(AW)) bus ();

   wb8_rr_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
      .I_wb_clk (clk),
      .I_reset  (rst),
      .bus      (bus.slave)
   );

   int checks = 0;
   int errors = 0;

   // stimulus
   logic [N-1:0]  stb, we;
   logic [AW-1:0] adr [N];
   logic [7:0]    dat [N];
   logic          s_ack;
   logic [7:0]    s_dat;

   // model: owner = -1 when no transaction is in flight
   int owner   = -1;
   int last    = N - 1;
   int busy_n  = 0;
   int fin_ack = -1;   // master that completed last edge (-1 none)

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      bus.I_m_stb = stb;
      bus.I_m_we  = we;
      for (int i = 0; i < N; i++) begin
         bus.I_m_adr[i*AW +: AW] = adr[i];
         bus.I_m_dat[i*8 +: 8]   = dat[i];
      end
      bus.I_s_ack = s_ack;
      bus.I_s_dat = s_dat;
   endtask

   task automatic check_outputs();
      logic [N-1:0]  e_ack, e_err, e_gnt;
      logic          e_sstb, e_swe;
      logic [AW-1:0] e_sadr;
      logic [7:0]    e_sdat, e_mdat;
      e_ack = '0; e_err = '0; e_gnt = '0;
      e_sstb = 1'b0; e_swe = 1'b0; e_sadr = '0; e_sdat = '0; e_mdat = '0;
      if (owner >= 0) begin
         e_gnt[owner] = 1'b1;
         e_sstb = stb[owner];
         e_swe  = we[owner];
         e_sadr = adr[owner];
         e_sdat = dat[owner];
         e_mdat = s_dat;
         if (s_ack) e_ack[owner] = 1'b1;
         else if (TO_EN && stb[owner] && (busy_n + 1 == TO)) e_err[owner] = 1'b1;
      end
      chk("grant", bus.O_grant, e_gnt);
      chk("s_stb", bus.O_s_stb, e_sstb);
      chk("s_we",  bus.O_s_we,  e_swe);
      chk("s_adr", bus.O_s_adr, e_sadr);
      chk("s_dat", bus.O_s_dat, e_sdat);
      chk("m_dat", bus.O_m_dat, e_mdat);
      chk("m_ack", bus.O_m_ack, e_ack);
      chk("m_err", bus.O_m_err, e_err);
   endtask

   // Transaction-level update at a clock edge.
   task automatic model_update();
      bit found;
      fin_ack = -1;
      if (owner < 0) begin
         found = 1'b0;
         for (int k = 1; k <= N; k++) begin
            if (!found && stb[(last + k) % N]) begin
               owner  = (last + k) % N;
               busy_n = 0;
               found  = 1'b1;
            end
         end
      end else begin
         busy_n++;
         if (s_ack || !stb[owner] || (TO_EN && busy_n == TO)) begin
            if (s_ack || (TO_EN && stb[owner])) fin_ack = owner;
            last  = owner;
            owner = -1;
         end
      end
   endtask

   task automatic half();
      @(negedge clk);
      drive();
      #1;
      check_outputs();
   endtask

   task automatic post();
      @(posedge clk);
      model_update();
   endtask

   task automatic clear();
      stb = '0; s_ack = 1'b0;
      half(); post();
   endtask

   logic [N-1:0] prev_g;
   int           err_at;

   initial begin
      stb = '0; we = '0; s_ack = 1'b0; s_dat = '0;
      for (int i = 0; i < N; i++) begin adr[i] = '0; dat[i] = '0; end
      drive();

      // reset state
      #3;
      check_outputs();
      @(negedge clk);
      rst = 1'b0;

      // 1: M0 write adr=3 dat=A5, ack one cycle after strobe
      stb = 2'b01; we = 2'b01; adr[0] = 4'd3; dat[0] = 8'hA5;
      half(); chk("t1_arb_sstb", bus.O_s_stb, 1'b0); post();
      half(); chk("t1_sstb", bus.O_s_stb, 1'b1); chk("t1_sdat", bus.O_s_dat, 8'hA5);
      chk("t1_sadr", bus.O_s_adr, 4'd3); post();
      s_ack = 1'b1;
      half(); chk("t1_ack", bus.O_m_ack, 2'b01); post();
      clear();

      // 2: both request continuously, slave acks immediately
      stb = 2'b11; we = 2'b00; s_ack = 1'b1; prev_g = '0;
      for (int c = 0; c < 16; c++) begin
         s_dat = 8'(c);
         half();
         if (bus.O_grant != '0) begin
            if (prev_g != '0) chk("t2_alternate", 32'(bus.O_grant !== prev_g), 32'd1);
            prev_g = bus.O_grant;
         end
         post();
      end
      clear();

      // 3: M1 read, slave returns 3C
      stb = 2'b10; we = 2'b00; adr[1] = 4'd5; s_dat = 8'h3C;
      half(); post();
      half(); post();
      s_ack = 1'b1;
      half(); chk("t3_mdat", bus.O_m_dat, 8'h3C); chk("t3_ack", bus.O_m_ack, 2'b10); post();
      clear();

      // 4: M0 aborts, late ack in IDLE ignored, M1 served next
      stb = 2'b11;
      half(); post();
      stb = 2'b10;
      half(); chk("t4_abort_ack", bus.O_m_ack, 2'b00); post();
      s_ack = 1'b1;
      half(); chk("t4_late_ack", bus.O_m_ack, 2'b00); post();
      half(); chk("t4_m1_ack", bus.O_m_ack, 2'b10); post();
      clear();

      // 5: asynchronous reset mid-BUSY
      stb = 2'b01; we = 2'b01; dat[0] = 8'h5A;
      half(); post();
      half(); chk("t5_busy_sstb", bus.O_s_stb, 1'b1); post();
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      owner = -1; last = N - 1; busy_n = 0;
      chk("t5_rst_sstb", bus.O_s_stb, 1'b0);
      chk("t5_rst_grant", bus.O_grant, 2'b00);
      chk("t5_rst_ack", bus.O_m_ack, 2'b00);
      stb = '0; s_ack = 1'b0; drive();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      stb = 2'b11;
      half(); post();
      s_ack = 1'b1;
      half(); chk("t5_m0_wins", bus.O_grant, 2'b01); post();
      clear();

`ifdef WB8_ARB_TIMEOUT_EN
      // 6: slave never acks
      stb = 2'b11; s_ack = 1'b0; err_at = -1;
      for (int c = 0; c < 24; c++) begin
         half();
         if (err_at < 0 && bus.O_m_err != '0) err_at = c;
         post();
      end
      chk("t6_err_cycle", err_at, 32'd16);
      clear();
`endif

      // randomized traffic
      for (int c = 0; c < 800; c++) begin
         for (int i = 0; i < N; i++) begin
            if (fin_ack == i) begin
               stb[i] = 1'($urandom_range(0, 1));
               we[i] = 1'($urandom); adr[i] = AW'($urandom); dat[i] = 8'($urandom);
            end else if (stb[i]) begin
               if ($urandom_range(0, 11) == 0) stb[i] = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
               stb[i] = 1'b1;
               we[i] = 1'($urandom); adr[i] = AW'($urandom); dat[i] = 8'($urandom);
            end
         end
         s_ack = ($urandom_range(0, 2) == 0);
         s_dat = 8'($urandom);
         half(); post();
      end
      clear();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
